// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: serial peek/poke responder that turns UART command bytes into
// single ARC bus transactions and streams the reply bytes back to the UART.
module uart_cmd_bridge #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_BIT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    SEND
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              is_wr, is_wr_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic [TO_BIT-1:0] to_cnt, to_cnt_nxt;
  logic [7:0]        w_data_nxt;
  logic [15:0]       mem_addr_nxt;
  logic [31:0]       mem_wdata_nxt;
  logic [31:0]       shreg_in;

  assign rd_uart  = ((state == IDLE) || (state == GET_ADDR) || (state == GET_DATA)) && !rx_empty;
  assign wr_uart  = (state == SEND) && !tx_full;
  assign shreg_in = {shreg[23:0], r_data};

  // Next-state, field assembly, bus timeout and reply serialization
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    is_wr_nxt     = is_wr;
    shreg_nxt     = shreg;
    to_cnt_nxt    = to_cnt;
    w_data_nxt    = w_data;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (rd_uart) begin
          cnt_nxt = 3'd0;
          if ((r_data == OP_WR) || (r_data == OP_RD)) begin
            is_wr_nxt = (r_data == OP_WR);
            state_nxt = GET_ADDR;
          end else begin
            w_data_nxt = RSP_BAD;
            state_nxt  = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rd_uart) begin
          shreg_nxt = shreg_in;
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd1) begin
            mem_addr_nxt = shreg_in[15:0];
            cnt_nxt      = 3'd0;
            to_cnt_nxt   = '0;
            state_nxt    = is_wr ? GET_DATA : BUS_RD;
          end
        end
      end
      GET_DATA: begin
        if (rd_uart) begin
          shreg_nxt = shreg_in;
          cnt_nxt   = cnt + 3'd1;
          if (cnt == 3'd3) begin
            mem_wdata_nxt = shreg_in;
            cnt_nxt       = 3'd0;
            to_cnt_nxt    = '0;
            state_nxt     = BUS_WR;
          end
        end
      end
      BUS_WR, BUS_RD: begin
        // An ack in the final allowed cycle still wins over the timeout
        state_nxt = SEND;
        cnt_nxt   = 3'd0;
        if (mem_ack) begin
          if (state == BUS_RD) begin
            w_data_nxt = mem_rdata[31:24];
            shreg_nxt  = {mem_rdata[23:0], 8'h00};
            cnt_nxt    = 3'd3;
          end else begin
            w_data_nxt = RSP_OK;
          end
        end else if (to_cnt == TO_LAST) begin
          w_data_nxt = RSP_ERR;
        end else begin
          state_nxt  = state;
          to_cnt_nxt = to_cnt + TO_BIT'(1);
        end
      end
      SEND: begin
        if (wr_uart) begin
          if (cnt == 3'd0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt    = cnt - 3'd1;
            w_data_nxt = shreg[31:24];
            shreg_nxt  = {shreg[23:0], 8'h00};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; strobes and busy follow the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      is_wr     <= 1'b0;
      shreg     <= 32'h0;
      to_cnt    <= '0;
      w_data    <= 8'h00;
      mem_addr  <= 16'h0000;
      mem_wdata <= 32'h0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      is_wr     <= is_wr_nxt;
      shreg     <= shreg_nxt;
      to_cnt    <= to_cnt_nxt;
      w_data    <= w_data_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_we    <= (state_nxt == BUS_WR);
      mem_re    <= (state_nxt == BUS_RD);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: drives uart_cmd_bridge from an RX byte queue, a TX sink and a
// bus responder, checking replies and bus transactions against expected results.
module tb_uart_cmd_bridge;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned TO_BIT  = 4;
  localparam int NV = 9;

  logic        clk;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_bridge #(.TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)) dut (
    .clk(clk), .reset(reset),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  typedef struct {
    logic [55:0] cmd;   // command bytes, first byte in the top bits
    int          ncmd;
    int          delay; // strobe cycle carrying the ack, 0 = never
    logic [31:0] rdata;
    int          gap;
    int          full;
    logic [31:0] tx;    // expected reply bytes, first byte in the top bits
    int          ntx;
    int          nbus;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          len;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bus_t        busq[$];
  int          ack_dq[$];
  logic [31:0] rdq[$];
  logic [7:0]  exp_tx[$];
  bus_t        exp_bus[$];

  int   gap_pct = 0;
  int   full_pct = 0;
  bit   stray = 1'b0;
  int   cyc = 0;
  int   strobe_len = 0;
  int   cur_delay = 0;
  logic [31:0] cur_rdata;
  bus_t cur;
  int   viol, pop_n, first_pop, last_pop, first_push, last_push;
  int   strobe_first, strobe_last, busy_first, busy_last;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_trace();
    viol = 0; pop_n = 0;
    first_pop = -1; last_pop = -1; first_push = -1; last_push = -1;
    strobe_first = -1; strobe_last = -1; busy_first = -1; busy_last = -1;
  endtask

  // One clock period: drive inputs at negedge, observe settled outputs 1ns later
  task automatic cycle();
    @(negedge clk);
    cyc++;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (mem_we || mem_re) begin
      if (strobe_len == 0) begin
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.len = 0;
        cur_delay = (ack_dq.size() > 0) ? ack_dq.pop_front() : 0;
        cur_rdata = (rdq.size() > 0) ? rdq.pop_front() : 32'h0;
        if (strobe_first < 0) strobe_first = cyc;
      end else if (mem_addr !== cur.addr || mem_wdata !== cur.wdata || mem_we !== cur.we) begin
        viol++;
      end
      if (mem_we && mem_re) viol++;
      strobe_len++;
      strobe_last = cyc;
      if (strobe_len == cur_delay) begin
        mem_ack = 1'b1;
        mem_rdata = cur_rdata;
      end
    end else begin
      if (strobe_len != 0) begin
        cur.len = strobe_len;
        busq.push_back(cur);
        strobe_len = 0;
      end
      if (stray) mem_ack = ($urandom_range(3) == 0);
    end
    rx_empty = (rxq.size() == 0) || (int'($urandom_range(99)) < gap_pct);
    r_data   = rx_empty ? 8'($urandom) : rxq[0];
    tx_full  = (int'($urandom_range(99)) < full_pct);
    #1;
    if (rd_uart) begin
      if (rx_empty) viol++;
      else begin
        void'(rxq.pop_front());
        pop_n++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (wr_uart) begin
      if (tx_full) viol++;
      else begin
        txq.push_back(w_data);
        if (first_push < 0) first_push = cyc;
        last_push = cyc;
      end
    end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  endtask

  task automatic run_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(rxq.size() == 0 && !busy && !rd_uart) && n < budget);
    check({name, " finished within budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rd_uart"}, 64'(rd_uart), 64'd0);
    check({name, " wr_uart"}, 64'(wr_uart), 64'd0);
    check({name, " mem_we"}, 64'(mem_we), 64'd0);
    check({name, " mem_re"}, 64'(mem_re), 64'd0);
    check({name, " busy"}, 64'(busy), 64'd0);
    check({name, " w_data"}, 64'(w_data), 64'h00);
    check({name, " mem_addr"}, 64'(mem_addr), 64'h0000);
    check({name, " mem_wdata"}, 64'(mem_wdata), 64'h0);
  endtask

  task automatic compare_results(input string name);
    check({name, " tx count"}, 64'(txq.size()), 64'(exp_tx.size()));
    for (int k = 0; k < exp_tx.size() && k < txq.size(); k++)
      check($sformatf("%s tx[%0d]", name, k), 64'(txq[k]), 64'(exp_tx[k]));
    check({name, " bus count"}, 64'(busq.size()), 64'(exp_bus.size()));
    for (int k = 0; k < exp_bus.size() && k < busq.size(); k++) begin
      check($sformatf("%s bus[%0d] we", name, k), 64'(busq[k].we), 64'(exp_bus[k].we));
      check($sformatf("%s bus[%0d] addr", name, k), 64'(busq[k].addr), 64'(exp_bus[k].addr));
      if (exp_bus[k].we)
        check($sformatf("%s bus[%0d] wdata", name, k), 64'(busq[k].wdata), 64'(exp_bus[k].wdata));
      check($sformatf("%s bus[%0d] len", name, k), 64'(busq[k].len), 64'(exp_bus[k].len));
    end
    check({name, " protocol violations"}, 64'(viol), 64'd0);
  endtask

  function automatic vec_t mk(logic [55:0] cmd, int ncmd, int delay, logic [31:0] rdata,
                              int gap, int full, logic [31:0] tx, int ntx, int nbus,
                              logic we, logic [15:0] addr, logic [31:0] wdata, int len);
    vec_t v;
    v.cmd = cmd; v.ncmd = ncmd; v.delay = delay; v.rdata = rdata;
    v.gap = gap; v.full = full; v.tx = tx; v.ntx = ntx; v.nbus = nbus;
    v.we = we; v.addr = addr; v.wdata = wdata; v.len = len;
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    string nm;
    reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    clear_trace();

    vecs[0] = mk(56'h571234DEADBEEF, 7,  3, 32'h0,        0,  0, 32'h4B000000, 1, 1, 1'b1, 16'h1234, 32'hDEADBEEF, 3);
    vecs[1] = mk(56'h52001000000000, 3,  2, 32'hCAFEF00D, 0,  0, 32'hCAFEF00D, 4, 1, 1'b0, 16'h0010, 32'h0, 2);
    vecs[2] = mk(56'h41000000000000, 1,  0, 32'h0,        0,  0, 32'h3F000000, 1, 0, 1'b0, 16'h0000, 32'h0, 0);
    vecs[3] = mk(56'h52000100000000, 3,  1, 32'h89ABCDEF, 0,  0, 32'h89ABCDEF, 4, 1, 1'b0, 16'h0001, 32'h0, 1);
    vecs[4] = mk(56'h57A55A01234567, 7,  0, 32'h0,        0,  0, 32'h45000000, 1, 1, 1'b1, 16'hA55A, 32'h01234567, 15);
    vecs[5] = mk(56'h52FFFE00000000, 3, 16, 32'h11111111, 0,  0, 32'h45000000, 1, 1, 1'b0, 16'hFFFE, 32'h0, 15);
    vecs[6] = mk(56'h52555500000000, 3, 15, 32'h13579BDF, 0,  0, 32'h13579BDF, 4, 1, 1'b0, 16'h5555, 32'h0, 15);
    vecs[7] = mk(56'h52002000000000, 3,  4, 32'h0BADC0DE, 60, 50, 32'h0BADC0DE, 4, 1, 1'b0, 16'h0020, 32'h0, 4);
    vecs[8] = mk(56'h5780010F1E2D3C, 7,  5, 32'h0,        50, 70, 32'h4B000000, 1, 1, 1'b1, 16'h8001, 32'h0F1E2D3C, 5);

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      nm = $sformatf("v%0d", i);
      clear_trace();
      gap_pct = v.gap; full_pct = v.full;
      txq.delete(); busq.delete(); exp_tx.delete(); exp_bus.delete();
      for (int k = 0; k < v.ncmd; k++) rxq.push_back(v.cmd[55-8*k -: 8]);
      for (int k = 0; k < v.ntx; k++) exp_tx.push_back(v.tx[31-8*k -: 8]);
      if (v.nbus > 0) begin
        ack_dq.push_back(v.delay);
        rdq.push_back(v.rdata);
        exp_bus.push_back('{we: v.we, addr: v.addr, wdata: v.wdata, len: v.len});
      end
      run_idle(400, nm);
      repeat (2) cycle();
      compare_results(nm);
      if (v.gap == 0 && v.full == 0) begin
        check({nm, " pops"}, 64'(pop_n), 64'(v.ncmd));
        check({nm, " pops back-to-back"}, 64'(last_pop - first_pop), 64'(v.ncmd - 1));
        check({nm, " busy rise"}, 64'(busy_first), 64'(first_pop + 1));
        check({nm, " busy fall"}, 64'(busy_last), 64'(last_push));
        check({nm, " reply back-to-back"}, 64'(last_push - first_push), 64'(v.ntx - 1));
        if (v.nbus > 0) begin
          check({nm, " strobe start"}, 64'(strobe_first), 64'(last_pop + 1));
          check({nm, " first push after strobe"}, 64'(first_push), 64'(strobe_last + 1));
        end else begin
          check({nm, " first push after pop"}, 64'(first_push), 64'(last_pop + 1));
        end
      end
    end

    // Reset in GET_DATA after two data bytes, then a fresh write
    clear_trace();
    gap_pct = 0; full_pct = 0;
    txq.delete(); busq.delete(); exp_tx.delete(); exp_bus.delete();
    rxq = '{8'h57, 8'h11, 8'h22, 8'h33, 8'h44};
    repeat (6) cycle();
    check("midcmd busy before reset", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midcmd reset");
    @(negedge clk);
    reset = 1'b0;
    rxq = '{8'h57, 8'hAB, 8'hCD, 8'h01, 8'h02, 8'h03, 8'h04};
    ack_dq.push_back(2); rdq.push_back(32'h0);
    exp_tx.push_back(8'h4B);
    exp_bus.push_back('{we: 1'b1, addr: 16'hABCD, wdata: 32'h01020304, len: 2});
    run_idle(400, "after reset");
    repeat (2) cycle();
    compare_results("after reset");

    // Randomized command stream against the command-level model
    clear_trace();
    gap_pct = 20; full_pct = 20; stray = 1'b1;
    txq.delete(); busq.delete(); exp_tx.delete(); exp_bus.delete();
    for (int n = 0; n < 40; n++) begin
      int sel, dly, len;
      bit ok;
      logic [7:0]  op;
      logic [15:0] a;
      logic [31:0] d, rd;
      sel = int'($urandom_range(9));
      a = 16'($urandom); d = $urandom; rd = $urandom;
      dly = int'($urandom_range(TIMEOUT + 3));
      ok  = (dly != 0) && (dly <= int'(TIMEOUT));
      len = ok ? dly : int'(TIMEOUT);
      if (sel < 8) begin
        op = (sel < 4) ? 8'h57 : 8'h52;
        rxq.push_back(op); rxq.push_back(a[15:8]); rxq.push_back(a[7:0]);
        if (sel < 4) for (int b = 3; b >= 0; b--) rxq.push_back(d[8*b +: 8]);
        ack_dq.push_back(dly); rdq.push_back(rd);
        exp_bus.push_back('{we: (sel < 4), addr: a, wdata: d, len: len});
        if (!ok) exp_tx.push_back(8'h45);
        else if (sel < 4) exp_tx.push_back(8'h4B);
        else for (int b = 3; b >= 0; b--) exp_tx.push_back(rd[8*b +: 8]);
      end else begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
        rxq.push_back(op);
        exp_tx.push_back(8'h3F);
      end
    end
    run_idle(20000, "random");
    repeat (2) cycle();
    compare_results("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
